// File: rtl/votrax_phone_timer.sv
// Phone duration timer: accepts a phone code on a strobe rising edge and holds
// ar low for (L+1) frames, L coming from a writable per-phone duration table.
module votrax_phone_timer #(
    parameter int          CLK_DIV     = 70,
    parameter int          FRAME_TICKS = 128,
    parameter logic [7:0]  DEFAULT_LEN = 8'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] p_input,
    input  logic       stb,
    input  logic       tbl_we,
    input  logic [5:0] tbl_addr,
    input  logic [7:0] tbl_data,
    output logic       ar,
    output logic [5:0] cur_phone,
    output logic       frame_pulse,
    output logic       phone_done,
    output logic       overrun
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_MAX = TW'(FRAME_TICKS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            stb_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [TW-1:0]   tif_q, tif_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic [7:0]      len_q, len_d;
    logic [5:0]      cur_phone_q, cur_phone_d;
    logic            ar_q, ar_d;
    logic            frame_pulse_q, frame_pulse_d;
    logic            phone_done_q, phone_done_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      table_q [64];
    logic [7:0]      table_d [64];

    logic            start_s;
    logic            tick_s;
    logic            frame_end_s;
    logic            final_s;
    logic [7:0]      rd_len_s;

    // Event decode: start edge, prescaler tick, frame end and last tick of the phone
    always_comb begin
        start_s     = stb & ~stb_q;
        tick_s      = (state_q == ST_PLAY) && (presc_q == P_MAX);
        frame_end_s = tick_s && (tif_q == T_MAX);
        final_s     = frame_end_s && (frame_cnt_q == len_q);
        // Table is read from the registered copy, so a same-cycle write is not seen
        rd_len_s    = table_q[p_input];
    end

    // Duration table next value
    always_comb begin
        table_d = table_q;
        if (tbl_we) begin
            table_d[tbl_addr] = tbl_data;
        end else begin
            table_d = table_q;
        end
    end

    // Timing FSM next state and counter updates
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        tif_d       = tif_q;
        frame_cnt_d = frame_cnt_q;
        len_d       = len_q;
        cur_phone_d = cur_phone_q;
        if (start_s) begin
            state_d     = ST_PLAY;
            presc_d     = '0;
            tif_d       = '0;
            frame_cnt_d = 8'd0;
            len_d       = rd_len_s;
            cur_phone_d = p_input;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (final_s) begin
                        state_d = ST_IDLE;
                    end else if (tick_s) begin
                        presc_d = '0;
                        if (frame_end_s) begin
                            tif_d       = '0;
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end else begin
                            tif_d = tif_q + TW'(1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output next values; frame_pulse is predicted one cycle ahead so the flop lands on the tick
    always_comb begin
        ar_d          = (state_d == ST_IDLE);
        frame_pulse_d = (state_d == ST_PLAY) && (presc_d == P_MAX) && (tif_d == T_MAX);
        phone_done_d  = final_s && !start_s;
        overrun_d     = start_s && (state_q == ST_PLAY);
    end

    // State, counters, table and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            stb_q         <= 1'b1;
            presc_q       <= '0;
            tif_q         <= '0;
            frame_cnt_q   <= 8'd0;
            len_q         <= 8'd0;
            cur_phone_q   <= 6'h3F;
            ar_q          <= 1'b1;
            frame_pulse_q <= 1'b0;
            phone_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                table_q[i] <= DEFAULT_LEN;
            end
        end else begin
            state_q       <= state_d;
            stb_q         <= stb;
            presc_q       <= presc_d;
            tif_q         <= tif_d;
            frame_cnt_q   <= frame_cnt_d;
            len_q         <= len_d;
            cur_phone_q   <= cur_phone_d;
            ar_q          <= ar_d;
            frame_pulse_q <= frame_pulse_d;
            phone_done_q  <= phone_done_d;
            overrun_q     <= overrun_d;
            table_q       <= table_d;
        end
    end

    assign ar          = ar_q;
    assign cur_phone   = cur_phone_q;
    assign frame_pulse = frame_pulse_q;
    assign phone_done  = phone_done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_votrax_phone_timer.sv
// Directed bench for votrax_phone_timer with CLK_DIV=4, FRAME_TICKS=2 (8 cycles per frame).
module tb_votrax_phone_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] p_input;
    logic       stb;
    logic       tbl_we;
    logic [5:0] tbl_addr;
    logic [7:0] tbl_data;
    logic       ar;
    logic [5:0] cur_phone;
    logic       frame_pulse;
    logic       phone_done;
    logic       overrun;

    votrax_phone_timer #(
        .CLK_DIV     (4),
        .FRAME_TICKS (2),
        .DEFAULT_LEN (8'd15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .p_input     (p_input),
        .stb         (stb),
        .tbl_we      (tbl_we),
        .tbl_addr    (tbl_addr),
        .tbl_data    (tbl_data),
        .ar          (ar),
        .cur_phone   (cur_phone),
        .frame_pulse (frame_pulse),
        .phone_done  (phone_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] code;
        logic [7:0] len;
        int         exp_low;
        int         exp_frames;
    } vec_t;

    vec_t vecs [5];
    int   n_checks = 0;
    int   n_fail   = 0;

    int         low, frames, fp_bad, dones, done_at, ovrs, ovr_at, fps, ar_hi;
    logic [5:0] ph;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic write_tbl(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        tbl_we = 1'b1; tbl_addr = a; tbl_data = d;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    // Strobe one phone at cycle 0 and observe until ar returns high (bounded)
    task automatic run_phone(input logic [5:0] code, output int o_low, output int o_frames,
                             output int o_fp_bad, output int o_dones, output int o_done_at,
                             output logic [5:0] o_ph);
        o_low = 0; o_frames = 0; o_fp_bad = 0; o_dones = 0; o_done_at = -1; o_ph = 6'h00;
        @(negedge clk);
        stb = 1'b1; p_input = code;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (k == 1) begin
                stb  = 1'b0;
                o_ph = cur_phone;
            end
            if (!ar) o_low++;
            if (frame_pulse) begin
                o_frames++;
                if (k % 8 != 0) o_fp_bad++;
            end
            if (phone_done) begin
                o_dones++;
                o_done_at = k;
            end
            if (ar) break;
        end
    endtask

    initial begin
        vecs[0] = '{code: 6'd5,  len: 8'd2,   exp_low: 24,   exp_frames: 3};
        vecs[1] = '{code: 6'd9,  len: 8'd0,   exp_low: 8,    exp_frames: 1};
        vecs[2] = '{code: 6'h3F, len: 8'd1,   exp_low: 16,   exp_frames: 2};
        vecs[3] = '{code: 6'd0,  len: 8'd3,   exp_low: 32,   exp_frames: 4};
        vecs[4] = '{code: 6'h21, len: 8'd255, exp_low: 2048, exp_frames: 256};

        reset = 1'b1; stb = 1'b0; p_input = 6'd0;
        tbl_we = 1'b0; tbl_addr = 6'd0; tbl_data = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_ar", int'(ar), 1);
        check("reset_cur_phone", int'(cur_phone), 'h3F);
        check("reset_frame_pulse", int'(frame_pulse), 0);
        check("reset_phone_done", int'(phone_done), 0);
        check("reset_overrun", int'(overrun), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven single phones, including L=0, L=255 and code 3F
        for (int v = 0; v < 5; v++) begin
            write_tbl(vecs[v].code, vecs[v].len);
            run_phone(vecs[v].code, low, frames, fp_bad, dones, done_at, ph);
            check($sformatf("vec%0d_ar_low", v), low, vecs[v].exp_low);
            check($sformatf("vec%0d_frames", v), frames, vecs[v].exp_frames);
            check($sformatf("vec%0d_frame_pos", v), fp_bad, 0);
            check($sformatf("vec%0d_done_cnt", v), dones, 1);
            check($sformatf("vec%0d_done_at", v), done_at, vecs[v].exp_low + 1);
            check($sformatf("vec%0d_cur_phone", v), int'(ph), int'(vecs[v].code));
            fps = 0; ar_hi = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (frame_pulse) fps++;
                if (ar) ar_hi++;
            end
            check($sformatf("vec%0d_idle_fp", v), fps, 0);
            check($sformatf("vec%0d_idle_ar", v), ar_hi, 6);
        end

        // Overrun: phone 5 (L=2) aborted by phone 7 (L=0) ten cycles later
        write_tbl(6'd5, 8'd2);
        write_tbl(6'd7, 8'd0);
        ovrs = 0; ovr_at = -1; dones = 0; done_at = -1; low = 0; ph = 6'd0;
        @(negedge clk); stb = 1'b1; p_input = 6'd5;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 11) ph = cur_phone;
            if (overrun) begin ovrs++; ovr_at = k; end
            if (phone_done) begin dones++; done_at = k; end
            if (k >= 11 && !ar) low++;
            stb = (k == 10);
            p_input = (k == 10) ? 6'd7 : 6'd5;
        end
        check("ovr_count", ovrs, 1);
        check("ovr_at", ovr_at, 11);
        check("ovr_cur_phone", int'(ph), 7);
        check("ovr_done_count", dones, 1);
        check("ovr_done_at", done_at, 19);
        check("ovr_ar_low", low, 8);

        // stb held high for 40 cycles: one 8-cycle phone only
        write_tbl(6'd9, 8'd0);
        dones = 0; low = 0;
        @(negedge clk); stb = 1'b1; p_input = 6'd9;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (!ar) low++;
            if (phone_done) dones++;
            stb = (k < 40);
        end
        check("held_ar_low", low, 8);
        check("held_done_count", dones, 1);
        check("held_ar_end", int'(ar), 1);

        // Restart landing on the final tick of an 8-cycle phone
        ovrs = 0; ovr_at = -1; dones = 0; done_at = -1; low = 0;
        @(negedge clk); stb = 1'b1; p_input = 6'd9;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (overrun) begin ovrs++; ovr_at = k; end
            if (phone_done) begin dones++; done_at = k; end
            if (!ar) low++;
            stb = (k == 8);
        end
        check("final_restart_ar_low", low, 16);
        check("final_restart_ovr_at", ovr_at, 9);
        check("final_restart_ovr_count", ovrs, 1);
        check("final_restart_done_count", dones, 1);
        check("final_restart_done_at", done_at, 17);

        // Table write in the start cycle does not change the captured length
        write_tbl(6'd5, 8'd2);
        low = 0;
        @(negedge clk);
        stb = 1'b1; p_input = 6'd5; tbl_we = 1'b1; tbl_addr = 6'd5; tbl_data = 8'd0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            tbl_we = 1'b0; stb = 1'b0;
            if (!ar) low++;
        end
        check("samecyc_write_old_len", low, 24);
        run_phone(6'd5, low, frames, fp_bad, dones, done_at, ph);
        check("samecyc_write_new_len", low, 8);

        // Reset mid-phone, with stb rising during reset and held after it
        write_tbl(6'd5, 8'd2);
        ovrs = 0; dones = 0; low = 0; fps = 0; ph = 6'd0; ar_hi = 0;
        @(negedge clk); stb = 1'b1; p_input = 6'd5;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 12) begin
                ph    = cur_phone;
                ar_hi = int'(ar);
            end
            if (overrun) ovrs++;
            if (phone_done) dones++;
            if (k >= 12 && !ar) low++;
            if (k >= 12 && frame_pulse) fps++;
            reset = (k >= 10 && k <= 11);
            stb   = (k >= 10 && k <= 14);
        end
        check("rst_mid_ar", ar_hi, 1);
        check("rst_mid_cur_phone", int'(ph), 'h3F);
        check("rst_mid_ovr", ovrs, 0);
        check("rst_mid_done", dones, 0);
        check("rst_mid_no_start", low, 0);
        check("rst_mid_no_fp", fps, 0);
        run_phone(6'd5, low, frames, fp_bad, dones, done_at, ph);
        check("rst_default_len_low", low, 128);
        check("rst_default_len_frames", frames, 16);
        check("rst_default_len_done_at", done_at, 129);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
